// File: rtl/clock_pkg.sv
// Shared constants for the clock counter chain, plus the priority decode used by mod_n_counter.
package clock_pkg;

    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;
    localparam int HR24_MOD = 24;
    localparam int HR12_MOD = 12;
    localparam int SEC_W    = 6;
    localparam int MIN_W    = 6;
    localparam int HR_W     = 5;

    typedef enum logic [2:0] {
        CNT_HOLD   = 3'd0,
        CNT_CLEAR  = 3'd1,
        CNT_LOAD   = 3'd2,
        CNT_REJECT = 3'd3,
        CNT_STEP   = 3'd4
    } cnt_op_e;

    // Priority: reset > clr > ld > en > hold. A rejected load still wins over en.
    function automatic cnt_op_e cnt_op_sel(input logic reset, input logic clr, input logic ld,
                                           input logic ld_ok, input logic en);
        cnt_op_e op;
        if (reset || clr) begin
            op = CNT_CLEAR;
        end else if (ld) begin
            op = ld_ok ? CNT_LOAD : CNT_REJECT;
        end else if (en) begin
            op = CNT_STEP;
        end else begin
            op = CNT_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/mod_cnt_next.sv
// Next-count and terminal-count computation for mod_n_counter.
// The down path exists only when MOD_CNT_DOWN_EN is defined; otherwise dir is ignored.
module mod_cnt_next
    import clock_pkg::*;
#(
    parameter int WIDTH   = SEC_W,
    parameter int MODULUS = SEC_MOD
) (
    input  logic [WIDTH-1:0] cnt,
    input  logic             dir,
    output logic [WIDTH-1:0] cnt_next,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

`ifdef MOD_CNT_DOWN_EN
    // Wrap is decided by comparing before the step, so cnt never leaves 0..MODULUS-1.
    always_comb begin
        cnt_next = ZERO_VAL;
        tc       = 1'b0;
        if (dir) begin
            tc       = (cnt == ZERO_VAL);
            cnt_next = tc ? MAX_VAL : (cnt - ONE_VAL);
        end else begin
            tc       = (cnt == MAX_VAL);
            cnt_next = tc ? ZERO_VAL : (cnt + ONE_VAL);
        end
    end
`else
    logic unused_dir;
    assign unused_dir = dir;

    // Up-only step with wrap at MODULUS-1.
    always_comb begin
        cnt_next = ZERO_VAL;
        tc       = (cnt == MAX_VAL);
        if (tc) begin
            cnt_next = ZERO_VAL;
        end else begin
            cnt_next = cnt + ONE_VAL;
        end
    end
`endif

endmodule

// File: rtl/mod_n_counter.sv
// Modulo-N counter with clear, checked parallel load, enable and same-cycle carry for cascading.
// Down-counting is built only when MOD_CNT_DOWN_EN is defined.
module mod_n_counter
    import clock_pkg::*;
#(
    parameter int WIDTH   = SEC_W,
    parameter int MODULUS = SEC_MOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] cnt,
    output logic             carry,
    output logic             ld_err
);

    // One extra bit so MODULUS = 2^WIDTH is representable in the load check.
    localparam logic [WIDTH:0] MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             ld_err_q;
    logic             ld_err_d;
    logic [WIDTH-1:0] step_s;
    logic             tc_s;
    logic             ld_ok_s;
    cnt_op_e          op_s;

    assign ld_ok_s = ({1'b0, ld_data} < MOD_EXT);

    mod_cnt_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .cnt      (cnt_q),
        .dir      (dir),
        .cnt_next (step_s),
        .tc       (tc_s)
    );

    // Priority mux selecting the next count and the load-error pulse.
    always_comb begin
        op_s     = cnt_op_sel(reset, clr, ld, ld_ok_s, en);
        cnt_d    = cnt_q;
        ld_err_d = 1'b0;
        case (op_s)
            CNT_CLEAR:  cnt_d    = {WIDTH{1'b0}};
            CNT_LOAD:   cnt_d    = ld_data;
            CNT_REJECT: ld_err_d = 1'b1;
            CNT_STEP:   cnt_d    = step_s;
            CNT_HOLD:   cnt_d    = cnt_q;
            default:    cnt_d    = cnt_q;
        endcase
    end

    // Count and load-error registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= {WIDTH{1'b0}};
            ld_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ld_err_q <= ld_err_d;
        end
    end

    // Carry only when this edge is a genuine count step at terminal count.
    assign carry  = (op_s == CNT_STEP) & tc_s;
    assign cnt    = cnt_q;
    assign ld_err = ld_err_q;

endmodule

// File: tb/tb_mod_n_counter.sv
// Scoreboard bench for mod_n_counter: a single 60-counter plus a 60/60/24 cascade.
module tb_mod_n_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b0, clr = 1'b0, ld = 1'b0, en = 1'b0, dir = 1'b0;
    logic [5:0] ld_data = 6'd0;
    logic [5:0] cnt;
    logic       carry, ld_err;

    logic       c_reset = 1'b0, c_ld = 1'b0, c_en = 1'b0;
    logic [5:0] c_ld_s = 6'd0, c_ld_m = 6'd0;
    logic [4:0] c_ld_h = 5'd0;
    logic [5:0] s_cnt, m_cnt;
    logic [4:0] h_cnt;
    logic       s_carry, m_carry, h_carry, s_err, m_err, h_err;

    mod_n_counter #(.WIDTH(6), .MODULUS(60)) dut (
        .clk(clk), .reset(reset), .clr(clr), .ld(ld), .ld_data(ld_data), .en(en), .dir(dir),
        .cnt(cnt), .carry(carry), .ld_err(ld_err));

    mod_n_counter #(.WIDTH(6), .MODULUS(60)) u_sec (
        .clk(clk), .reset(c_reset), .clr(1'b0), .ld(c_ld), .ld_data(c_ld_s), .en(c_en), .dir(1'b0),
        .cnt(s_cnt), .carry(s_carry), .ld_err(s_err));

    mod_n_counter #(.WIDTH(6), .MODULUS(60)) u_min (
        .clk(clk), .reset(c_reset), .clr(1'b0), .ld(c_ld), .ld_data(c_ld_m), .en(s_carry), .dir(1'b0),
        .cnt(m_cnt), .carry(m_carry), .ld_err(m_err));

    mod_n_counter #(.WIDTH(5), .MODULUS(24)) u_hr (
        .clk(clk), .reset(c_reset), .clr(1'b0), .ld(c_ld), .ld_data(c_ld_h), .en(m_carry), .dir(1'b0),
        .cnt(h_cnt), .carry(h_carry), .ld_err(h_err));

    typedef struct {
        string      name;
        logic [5:0] cnt;
        logic       carry;
        logic       err;
        logic [5:0] s;
        logic [5:0] m;
        logic [4:0] h;
        logic [2:0] cy;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    logic [5:0] e_cnt = 6'd0, e_s = 6'd0, e_m = 6'd0;
    logic [4:0] e_h = 5'd0;
    logic       e_carry = 1'b0, e_err = 1'b0;
    logic [2:0] e_cy = 3'b000;

    task automatic push_exp(input string nm);
        exp_t x;
        x.name = nm; x.cnt = e_cnt; x.carry = e_carry; x.err = e_err;
        x.s = e_s; x.m = e_m; x.h = e_h; x.cy = e_cy;
        sb_q.push_back(x);
    endtask

    task automatic both_reset();
        @(negedge clk);
        reset = 1'b1; clr = 1'b0; ld = 1'b0; en = 1'b1; dir = 1'b0; ld_data = 6'd0;
        c_reset = 1'b1; c_ld = 1'b0; c_en = 1'b1;
        e_cnt = 6'd0; e_carry = 1'b0; e_err = 1'b0;
        e_s = 6'd0; e_m = 6'd0; e_h = 5'd0; e_cy = 3'b000;
        push_exp("reset");
    endtask

    task automatic single(input logic r, input logic c, input logic l, input logic [5:0] d,
                          input logic e, input logic dr, input logic [5:0] xcnt,
                          input logic xcarry, input logic xerr, input string nm);
        @(negedge clk);
        reset = r; clr = c; ld = l; ld_data = d; en = e; dir = dr;
        c_reset = 1'b0; c_ld = 1'b0; c_en = 1'b0;
        e_cnt = xcnt; e_carry = xcarry; e_err = xerr; e_cy = 3'b000;
        push_exp(nm);
    endtask

    task automatic chain(input logic l, input logic [5:0] ls, input logic [5:0] lm,
                         input logic [4:0] lh, input logic e, input logic [5:0] xs,
                         input logic [5:0] xm, input logic [4:0] xh, input logic [2:0] xcy,
                         input string nm);
        @(negedge clk);
        reset = 1'b0; clr = 1'b0; ld = 1'b0; en = 1'b0; dir = 1'b0;
        c_reset = 1'b0; c_ld = l; c_ld_s = ls; c_ld_m = lm; c_ld_h = lh; c_en = e;
        e_carry = 1'b0; e_err = 1'b0;
        e_s = xs; e_m = xm; e_h = xh; e_cy = xcy;
        push_exp(nm);
    endtask

    // Monitor: carry sampled late in the cycle, registered outputs just after the edge.
    always begin : monitor
        logic       samp_carry;
        logic [2:0] samp_cy;
        exp_t       x;
        @(negedge clk);
        #3;
        samp_carry = carry;
        samp_cy    = {h_carry, m_carry, s_carry};
        @(posedge clk);
        #1;
        if (sb_q.size() > 0) begin
            x = sb_q.pop_front();
            total += 1;
            if ({cnt, samp_carry, ld_err} !== {x.cnt, x.carry, x.err}) begin
                bad += 1;
                $display("FAIL %s single: got cnt=%0d carry=%b ld_err=%b, want cnt=%0d carry=%b ld_err=%b",
                         x.name, cnt, samp_carry, ld_err, x.cnt, x.carry, x.err);
            end
            total += 1;
            if ({s_cnt, m_cnt, h_cnt, samp_cy, s_err, m_err, h_err} !==
                {x.s, x.m, x.h, x.cy, 3'b000}) begin
                bad += 1;
                $display("FAIL %s chain: got %0d:%0d:%0d cy=%b err=%b%b%b, want %0d:%0d:%0d cy=%b err=000",
                         x.name, h_cnt, m_cnt, s_cnt, samp_cy, h_err, m_err, s_err,
                         x.h, x.m, x.s, x.cy);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : stimulus
        both_reset();

        for (int i = 0; i < 60; i++) begin
            single(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0,
                   (i == 59) ? 6'd0 : 6'(i + 1), (i == 59), 1'b0, "count_up");
        end

        single(1'b0, 1'b0, 1'b1, 6'd45, 1'b1, 1'b0, 6'd45, 1'b0, 1'b0, "load_45");
        for (int i = 0; i < 15; i++) begin
            single(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0,
                   (i == 14) ? 6'd0 : 6'(46 + i), (i == 14), 1'b0, "wrap_after_load");
        end

        single(1'b0, 1'b0, 1'b1, 6'd12, 1'b0, 1'b0, 6'd12, 1'b0, 1'b0, "load_12");
        single(1'b0, 1'b0, 1'b1, 6'd60, 1'b1, 1'b0, 6'd12, 1'b0, 1'b1, "reject_60");
        single(1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 6'd12, 1'b0, 1'b0, "err_falls");
        single(1'b0, 1'b0, 1'b1, 6'd63, 1'b0, 1'b0, 6'd12, 1'b0, 1'b1, "reject_63_a");
        single(1'b0, 1'b0, 1'b1, 6'd63, 1'b0, 1'b0, 6'd12, 1'b0, 1'b1, "reject_63_b");
        single(1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 6'd13, 1'b0, 1'b0, "step_after_err");

        single(1'b0, 1'b0, 1'b1, 6'd59, 1'b0, 1'b0, 6'd59, 1'b0, 1'b0, "load_59");
        single(1'b0, 1'b0, 1'b1, 6'd10, 1'b1, 1'b0, 6'd10, 1'b0, 1'b0, "ld_beats_en");
        single(1'b0, 1'b0, 1'b1, 6'd59, 1'b0, 1'b0, 6'd59, 1'b0, 1'b0, "load_59_b");
        single(1'b0, 1'b1, 1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  1'b0, 1'b0, "clr_at_59");
        single(1'b0, 1'b0, 1'b1, 6'd59, 1'b0, 1'b0, 6'd59, 1'b0, 1'b0, "load_59_c");
        single(1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 1'b0, 6'd0,  1'b0, 1'b0, "reset_at_59");
        single(1'b0, 1'b0, 1'b0, 6'd0,  1'b0, 1'b0, 6'd0,  1'b0, 1'b0, "hold");

`ifdef MOD_CNT_DOWN_EN
        single(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 6'd59, 1'b1, 1'b0, "down_borrow");
        single(1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b1, 6'd58, 1'b0, 1'b0, "down_step");
`else
        single(1'b0, 1'b0, 1'b1, 6'd59, 1'b0, 1'b0, 6'd59, 1'b0, 1'b0, "load_59_d");
        single(1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 1'b1, 6'd0,  1'b1, 1'b0, "dir_ignored_wrap");
        single(1'b0, 1'b0, 1'b0, 6'd0,  1'b1, 1'b1, 6'd1,  1'b0, 1'b0, "dir_ignored_step");
`endif

        chain(1'b1, 6'd59, 6'd58, 5'd23, 1'b0, 6'd59, 6'd58, 5'd23, 3'b000, "chain_load_a");
        chain(1'b0, 6'd0,  6'd0,  5'd0,  1'b1, 6'd0,  6'd59, 5'd23, 3'b001, "chain_sec_wrap");
        chain(1'b1, 6'd59, 6'd59, 5'd23, 1'b1, 6'd59, 6'd59, 5'd23, 3'b000, "chain_ld_no_carry");
        chain(1'b0, 6'd0,  6'd0,  5'd0,  1'b1, 6'd0,  6'd0,  5'd0,  3'b111, "chain_full_wrap");
        chain(1'b0, 6'd0,  6'd0,  5'd0,  1'b0, 6'd0,  6'd0,  5'd0,  3'b000, "chain_idle");

        @(negedge clk);
        reset = 1'b0; clr = 1'b0; ld = 1'b0; en = 1'b0; c_ld = 1'b0; c_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total += 1;
        if (sb_q.size() != 0) begin
            bad += 1;
            $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
